// File: rtl/dlx_hazard_unit.sv
// dlx_hazard_unit
//   Interlock and flush controller for the DLX pipeline, placed beside ID decode.
//   It keeps a per-register scoreboard of pending writes (load and multiply
//   latencies) and a busy counter for the non-pipelined multiplier. From these
//   it decides whether the instruction in ID stalls, is killed (flush slot after
//   a taken branch/jump) or issues.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs1/_used      source 1 index / instruction reads it
//   id_rs2/_used      source 2 index / instruction reads it
//   id_rd, id_regwr   destination index / instruction writes it
//   id_is_load        load instruction
//   id_is_mul         mult/multu
//   id_branch_taken   branch/jump in ID resolved taken
//   stall             hold PC and IF/ID, bubble into EX
//   kill              squash the instruction in ID
//   issue             ID instruction advances this cycle
//   busy_mask         bit i = register i has a pending write
//   mul_busy          multiplier occupied
module dlx_hazard_unit #(
  parameter int NREGS       = 32,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int MUL_LAT     = 4,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_branch_taken,
  output logic              stall,
  output logic              kill,
  output logic              issue,
  output logic [NREGS-1:0]  busy_mask,
  output logic              mul_busy
);

  localparam int MAXLAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int CW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);
  localparam int FW     = (FLUSH_SLOTS < 1) ? 1 : $clog2(FLUSH_SLOTS + 1);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  logic [CW-1:0] r_cnt [NREGS];
  logic [CW-1:0] r_mcnt;
  logic [FW-1:0] r_fcnt;
  state_t        r_state;

  state_t        w_state_nxt;
  logic [FW-1:0] w_fcnt_nxt;
  logic [NREGS-1:0] w_busy;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_set;
  logic [CW-1:0] w_set_val;

  // Entry 0 is never loaded, so r0 can never appear busy.
  always_comb begin
    w_busy = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  always_comb begin
    w_raw    = (id_rs1_used & w_busy[id_rs1]) | (id_rs2_used & w_busy[id_rs2]);
    w_waw    = id_regwr & w_busy[id_rd];
    w_struct = id_is_mul & (r_mcnt != '0);
    kill     = (r_state == S_FLUSH);
    stall    = id_valid & ~kill & (w_raw | w_waw | w_struct);
    issue    = id_valid & ~kill & ~stall;
    busy_mask = w_busy;
    mul_busy  = (r_mcnt != '0);
  end

  // Load takes precedence should both type flags be set; ALU results are forwarded.
  always_comb begin
    w_set     = issue & id_regwr & (id_rd != '0);
    w_set_val = '0;
    if (id_is_load)     w_set_val = CW'(LOAD_LAT);
    else if (id_is_mul) w_set_val = CW'(MUL_LAT);
  end

  // waw interlock guarantees the target counter is zero when it is loaded,
  // so a load never competes with a decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_mcnt <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (w_set && (id_rd == REG_AW'(i))) begin
          r_cnt[i] <= w_set_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
      if (issue && id_is_mul) begin
        r_mcnt <= CW'(MUL_LAT);
      end else if (r_mcnt != '0) begin
        r_mcnt <= r_mcnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      S_RUN: begin
        if (issue && id_branch_taken && (FLUSH_SLOTS > 0)) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FW'(FLUSH_SLOTS);
        end
      end
      S_FLUSH: begin
        w_fcnt_nxt = r_fcnt - FW'(1);
        if (r_fcnt == FW'(1)) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_dlx_hazard_unit.sv
module tb_dlx_hazard_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_rs1_used;
  logic [4:0]  id_rs2;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_regwr;
  logic        id_is_load;
  logic        id_is_mul;
  logic        id_branch_taken;
  logic        stall;
  logic        kill;
  logic        issue;
  logic [31:0] busy_mask;
  logic        mul_busy;

  int checks = 0;
  int errors = 0;

  dlx_hazard_unit #(
    .NREGS(32),
    .REG_AW(5),
    .LOAD_LAT(1),
    .MUL_LAT(4),
    .FLUSH_SLOTS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2),
    .id_rs2_used(id_rs2_used),
    .id_rd(id_rd),
    .id_regwr(id_regwr),
    .id_is_load(id_is_load),
    .id_is_mul(id_is_mul),
    .id_branch_taken(id_branch_taken),
    .stall(stall),
    .kill(kill),
    .issue(issue),
    .busy_mask(busy_mask),
    .mul_busy(mul_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // valid, rs1, rs1_used, rs2, rs2_used, rd, regwr, load, mul, taken
  task automatic set_id(input logic v, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic [4:0] d,
                        input logic w, input logic ld, input logic ml, input logic br);
    id_valid = v; id_rs1 = s1; id_rs1_used = u1; id_rs2 = s2; id_rs2_used = u2;
    id_rd = d; id_regwr = w; id_is_load = ld; id_is_mul = ml; id_branch_taken = br;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    check("rst_busy", busy_mask, 32'h0);
    check("rst_mulbusy", {31'b0, mul_busy}, 32'h0);
    check("rst_kill", {31'b0, kill}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_issue", {31'b0, issue}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: lw r3 ; add r4,r3,r1
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0);
    check("t1_lw_issue", {31'b0, issue}, 32'h1);
    tick();
    set_id(1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0);
    check("t1_busy3", busy_mask, 32'h8);
    check("t1_stall", {31'b0, stall}, 32'h1);
    check("t1_noissue", {31'b0, issue}, 32'h0);
    tick();
    check("t1_busy_clr", busy_mask, 32'h0);
    check("t1_nostall", {31'b0, stall}, 32'h0);
    check("t1_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();
    check("t1_after", busy_mask, 32'h0);

    // 2: mult r5 ; add r6,r5,r0
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 1, 0);
    check("t2_mul_issue", {31'b0, issue}, 32'h1);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_stall%0d", k), {31'b0, stall}, 32'h1);
      check($sformatf("t2_mulbusy%0d", k), {31'b0, mul_busy}, 32'h1);
      tick();
    end
    check("t2_use_issue", {31'b0, issue}, 32'h1);
    check("t2_mul_free", {31'b0, mul_busy}, 32'h0);
    tick();

    // 2b: mult r5 ; mult r9 (structural) ; then 5: rd=r10 with no sources
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 1, 0);
    check("t2b_mul1", {31'b0, issue}, 32'h1);
    tick();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2b_stall%0d", k), {31'b0, stall}, 32'h1);
      tick();
    end
    check("t2b_mul2_issue", {31'b0, issue}, 32'h1);
    tick();
    set_id(1, 5'd9, 0, 5'd9, 0, 5'd10, 1, 0, 0, 0);
    check("t5_busy9", busy_mask, 32'h200);
    check("t5_nostall", {31'b0, stall}, 32'h0);
    check("t5_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();
    check("t5_busy9_b", busy_mask, 32'h200);
    repeat (3) tick();
    check("t2b_drain", busy_mask, 32'h0);
    check("t2b_mul_drain", {31'b0, mul_busy}, 32'h0);

    // 3: taken beqz, two killed slots; lw r7 sits in the killed slots
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    check("t3_br_issue", {31'b0, issue}, 32'h1);
    check("t3_br_nokill", {31'b0, kill}, 32'h0);
    tick();
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0);
    check("t3_kill0", {31'b0, kill}, 32'h1);
    check("t3_noissue0", {31'b0, issue}, 32'h0);
    check("t3_nostall0", {31'b0, stall}, 32'h0);
    tick();
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1);
    check("t3_kill1", {31'b0, kill}, 32'h1);
    check("t3_noissue1", {31'b0, issue}, 32'h0);
    check("t3_busy7", busy_mask, 32'h0);
    tick();
    nop();
    check("t3_run", {31'b0, kill}, 32'h0);
    check("t3_busy7_b", busy_mask, 32'h0);
    tick();
    check("t3_stay_run", {31'b0, kill}, 32'h0);

    // 4: lw r0 ; add r4,r0,r0
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);
    check("t4_lw_issue", {31'b0, issue}, 32'h1);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0, 0);
    check("t4_busy", busy_mask, 32'h0);
    check("t4_nostall", {31'b0, stall}, 32'h0);
    check("t4_issue", {31'b0, issue}, 32'h1);
    tick();

    // 6: load r3 together with a taken jump, then reset mid-flush
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0, 1);
    check("t6_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();
    check("t6_kill", {31'b0, kill}, 32'h1);
    check("t6_busy3", busy_mask, 32'h8);
    reset = 1'b1;
    #1;
    check("t6_rst_kill", {31'b0, kill}, 32'h0);
    check("t6_rst_busy", busy_mask, 32'h0);
    check("t6_rst_issue", {31'b0, issue}, 32'h0);
    tick();
    reset = 1'b0;
    set_id(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 0, 0, 0);
    check("t6_run_kill", {31'b0, kill}, 32'h0);
    check("t6_run_issue", {31'b0, issue}, 32'h1);
    tick();
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
